// File: rtl/otter_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : otter_arb_pkg
// Purpose  : Shared types for the OTTER data-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package otter_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [1:0]            size;
        logic                  sign;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/otter_arb_req_mux.sv
`default_nettype none
// ============================================================================
// Module   : otter_arb_req_mux
// Purpose  : Selects the winning requester's access fields.
// Revision : 1.0 - initial release
// ============================================================================
module otter_arb_req_mux
    import otter_arb_pkg::*;
(
    input  req_id_t  i_sel,
    input  mem_req_t i_cpu,
    input  mem_req_t i_dbg,
    output mem_req_t o_req
);

    assign o_req = (i_sel == REQ_DBG) ? i_dbg : i_cpu;

endmodule
`default_nettype wire

// File: rtl/otter_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : otter_dmem_arbiter
// Purpose  : CPU / debug arbiter for OTTER memory data port 2.
// Revision : 1.0 - initial release
// ============================================================================
module otter_dmem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [1:0]        dbg_size,
    input  logic              dbg_sign,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_halt,
    output logic              mem_rden2,
    output logic              mem_we2,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_din2,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_dout2
);

    localparam int                 c_LAT_W   = $clog2(RD_LAT + 1);
    localparam int                 c_STV_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_MAX = c_LAT_W'(RD_LAT);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(MAX_WAIT);

    generate
        if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W || RD_LAT < 1 || MAX_WAIT < 1) begin : g_param_check
            $error("otter_dmem_arbiter: unsupported parameter set");
        end
    endgenerate

    arb_state_t           r_state;
    req_id_t              r_owner;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic [c_STV_W-1:0]   r_starve;
    logic [DATA_W-1:0]    r_cpu_rdata;
    logic [DATA_W-1:0]    r_dbg_rdata;

    logic                 w_idle;
    logic                 w_starved;
    logic                 w_cpu_win;
    logic                 w_dbg_win;
    logic                 w_issue;
    logic                 w_rd_done;
    req_id_t              w_gnt_id;
    mem_req_t             w_cpu_fields;
    mem_req_t             w_dbg_fields;
    mem_req_t             w_sel;

    assign w_cpu_fields = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, size: cpu_size, sign: cpu_sign};
    assign w_dbg_fields = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, size: dbg_size, sign: dbg_sign};

    // Gating with RST_N keeps every output quiet while reset is held, even with requests pending.
    assign w_idle    = (r_state == IDLE) && RST_N;
    assign w_starved = dbg_req && (r_starve == c_STV_MAX);
    assign w_cpu_win = w_idle && cpu_req && !dbg_halt && !w_starved;
    assign w_dbg_win = w_idle && dbg_req && !w_cpu_win;
    assign w_issue   = w_cpu_win || w_dbg_win;
    assign w_gnt_id  = w_dbg_win ? REQ_DBG : REQ_CPU;

    otter_arb_req_mux u_req_mux (
        .i_sel (w_gnt_id),
        .i_cpu (w_cpu_fields),
        .i_dbg (w_dbg_fields),
        .o_req (w_sel)
    );

    assign cpu_gnt   = w_cpu_win;
    assign dbg_gnt   = w_dbg_win;
    assign mem_we2   = w_issue && w_sel.we;
    assign mem_rden2 = w_issue && !w_sel.we;
    assign mem_addr2 = w_issue ? w_sel.addr  : '0;
    assign mem_din2  = w_issue ? w_sel.wdata : '0;
    assign mem_size  = w_issue ? w_sel.size  : 2'b00;
    assign mem_sign  = w_issue && w_sel.sign;

    // Read data is passed straight through on the valid cycle and held afterwards.
    assign w_rd_done  = (r_state == RD_WAIT) && (r_lat_cnt == c_LAT_MAX);
    assign cpu_rvalid = w_rd_done && (r_owner == REQ_CPU);
    assign dbg_rvalid = w_rd_done && (r_owner == REQ_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_dout2 : r_cpu_rdata;
    assign dbg_rdata  = dbg_rvalid ? mem_dout2 : r_dbg_rdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_owner   <= REQ_CPU;
            r_lat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (mem_rden2) begin
                r_state   <= RD_WAIT;
                r_owner   <= w_gnt_id;
                r_lat_cnt <= c_LAT_W'(1);
            end
        end else begin
            if (w_rd_done) begin
                r_state <= IDLE;
            end else begin
                r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_starve <= '0;
        end else if (!dbg_req || w_dbg_win) begin
            r_starve <= '0;
        end else if (r_starve != c_STV_MAX) begin
            r_starve <= r_starve + c_STV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (cpu_rvalid) r_cpu_rdata <= mem_dout2;
            if (dbg_rvalid) r_dbg_rdata <= mem_dout2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_dmem_arbiter
// Purpose  : Scoreboard bench for otter_dmem_arbiter (RD_LAT=1 and RD_LAT=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_dmem_arbiter;

    localparam int K_CG = 1;
    localparam int K_DG = 2;
    localparam int K_CR = 3;
    localparam int K_DR = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [2:0]  szsg;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] last_cpu [2];
    logic [31:0] last_dbg [2];

    logic        cpu_req [2], cpu_we [2], cpu_sign [2], cpu_gnt [2], cpu_rvalid [2];
    logic [31:0] cpu_addr [2], cpu_wdata [2], cpu_rdata [2];
    logic [1:0]  cpu_size [2];
    logic        dbg_req [2], dbg_we [2], dbg_sign [2], dbg_gnt [2], dbg_rvalid [2];
    logic [31:0] dbg_addr [2], dbg_wdata [2], dbg_rdata [2];
    logic [1:0]  dbg_size [2];
    logic        dbg_halt [2], mem_rden2 [2], mem_we2 [2], mem_sign [2];
    logic [31:0] mem_addr2 [2], mem_din2 [2], mem_dout2 [2];
    logic [1:0]  mem_size [2];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int L = (d == 0) ? 1 : 3;
        logic [31:0] r_dout = '0;
        logic [31:0] pd [2];
        logic        pv [2];

        otter_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L), .MAX_WAIT(4)) u_dut (
            .CLK(CLK), .RST_N(RST_N),
            .cpu_req(cpu_req[d]), .cpu_we(cpu_we[d]), .cpu_addr(cpu_addr[d]),
            .cpu_wdata(cpu_wdata[d]), .cpu_size(cpu_size[d]), .cpu_sign(cpu_sign[d]),
            .cpu_gnt(cpu_gnt[d]), .cpu_rvalid(cpu_rvalid[d]), .cpu_rdata(cpu_rdata[d]),
            .dbg_req(dbg_req[d]), .dbg_we(dbg_we[d]), .dbg_addr(dbg_addr[d]),
            .dbg_wdata(dbg_wdata[d]), .dbg_size(dbg_size[d]), .dbg_sign(dbg_sign[d]),
            .dbg_gnt(dbg_gnt[d]), .dbg_rvalid(dbg_rvalid[d]), .dbg_rdata(dbg_rdata[d]),
            .dbg_halt(dbg_halt[d]),
            .mem_rden2(mem_rden2[d]), .mem_we2(mem_we2[d]), .mem_addr2(mem_addr2[d]),
            .mem_din2(mem_din2[d]), .mem_size(mem_size[d]), .mem_sign(mem_sign[d]),
            .mem_dout2(mem_dout2[d])
        );

        // Memory model: read data = addr ^ A5A50000, valid L cycles after rden.
        always @(posedge CLK) begin
            pv[0] <= mem_rden2[d];
            pd[0] <= mem_addr2[d] ^ 32'hA5A5_0000;
            pv[1] <= pv[0];
            pd[1] <= pd[0];
            if (L == 1) begin
                if (mem_rden2[d]) r_dout <= mem_addr2[d] ^ 32'hA5A5_0000;
            end else begin
                if (pv[1]) r_dout <= pd[1];
            end
        end
        assign mem_dout2[d] = r_dout;
    end

    task automatic sb_push(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic sb_front(input int d, output bit ok, output exp_t e);
        ok = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (ok) e = (d == 0) ? sb0[0] : sb1[0];
    endtask

    task automatic sb_pop(input int d);
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic push_g(input int d, input int kind, input int c, input logic [31:0] addr,
                          input logic [31:0] data, input logic we, input logic [2:0] szsg);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.data = data; e.we = we; e.szsg = szsg;
        sb_push(d, e);
    endtask

    task automatic push_r(input int d, input int kind, input int c, input logic [31:0] data);
        push_g(d, kind, c, 32'h0, data, 1'b0, 3'b000);
    endtask

    task automatic monitor_one(input int d);
        int   kind, n;
        bit   ok, good;
        exp_t e;
        logic [31:0] rd;
        sb_front(d, ok, e);
        while (ok && e.cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event dut%0d: got nothing by cyc %0d, expected kind %0d at cyc %0d",
                     d, cyc, e.kind, e.cyc);
            sb_pop(d);
            sb_front(d, ok, e);
        end
        n = int'(cpu_gnt[d]) + int'(dbg_gnt[d]) + int'(cpu_rvalid[d]) + int'(dbg_rvalid[d]);
        checks++;
        if (n > 1) begin
            errors++;
            $display("FAIL one_event dut%0d cyc %0d: got %0d events, expected at most 1", d, cyc, n);
        end
        kind = cpu_gnt[d] ? K_CG : dbg_gnt[d] ? K_DG : cpu_rvalid[d] ? K_CR : dbg_rvalid[d] ? K_DR : 0;
        if (kind != 0) begin
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL unexpected_event dut%0d cyc %0d: got kind %0d, expected none", d, cyc, kind);
            end else begin
                sb_pop(d);
                rd = (kind == K_CR) ? cpu_rdata[d] : dbg_rdata[d];
                good = (e.kind == kind) && (e.cyc == cyc);
                if (kind == K_CG || kind == K_DG)
                    good = good && (mem_we2[d] === e.we) && (mem_rden2[d] === !e.we)
                           && (mem_addr2[d] === e.addr) && (mem_din2[d] === e.data)
                           && ({mem_size[d], mem_sign[d]} === e.szsg);
                else
                    good = good && (rd === e.data);
                if (e.kind == K_CR) last_cpu[d] = e.data;
                if (e.kind == K_DR) last_dbg[d] = e.data;
                if (!good) begin
                    errors++;
                    $display("FAIL event dut%0d cyc %0d: got kind %0d we %b rden %b addr %h din %h szsg %b rdata %h; expected kind %0d cyc %0d we %b addr %h data %h szsg %b",
                             d, cyc, kind, mem_we2[d], mem_rden2[d], mem_addr2[d], mem_din2[d],
                             {mem_size[d], mem_sign[d]}, rd, e.kind, e.cyc, e.we, e.addr, e.data, e.szsg);
                end
            end
        end else begin
            checks++;
            if ({mem_we2[d], mem_rden2[d], mem_addr2[d], mem_din2[d], mem_size[d], mem_sign[d]} !== '0
                || cpu_rdata[d] !== last_cpu[d] || dbg_rdata[d] !== last_dbg[d]) begin
                errors++;
                $display("FAIL idle_outputs dut%0d cyc %0d: got we %b rden %b addr %h din %h cpu_rdata %h dbg_rdata %h; expected zeros, cpu_rdata %h dbg_rdata %h",
                         d, cyc, mem_we2[d], mem_rden2[d], mem_addr2[d], mem_din2[d],
                         cpu_rdata[d], dbg_rdata[d], last_cpu[d], last_dbg[d]);
            end
        end
    endtask

    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) monitor_one(d);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drv(input int d, input bit dbg, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sg);
        if (!dbg) begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr;
            cpu_wdata[d] = wd; cpu_size[d] = sz; cpu_sign[d] = sg;
        end else begin
            dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = addr;
            dbg_wdata[d] = wd; dbg_size[d] = sz; dbg_sign[d] = sg;
        end
    endtask

    initial begin
        int b;
        for (int d = 0; d < 2; d++) begin
            drv(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            drv(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            dbg_halt[d] = 1'b0;
            last_cpu[d] = 32'h0;
            last_dbg[d] = 32'h0;
        end

        // Reset with requests pending: nothing may be issued.
        drv(0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 2'b10, 1'b0);
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 2'b10, 1'b0);
        step(2);
        chk("rst_cpu_gnt",   {31'h0, cpu_gnt[0]},   32'h0);
        chk("rst_dbg_gnt",   {31'h0, dbg_gnt[0]},   32'h0);
        chk("rst_mem_we2",   {31'h0, mem_we2[0]},   32'h0);
        chk("rst_mem_addr2", mem_addr2[0],          32'h0);
        chk("rst_cpu_rdata", cpu_rdata[0],          32'h0);
        chk("rst_dbg_rdata", dbg_rdata[0],          32'h0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        RST_N = 1'b1;
        step(2);

        // Lone CPU store.
        b = cyc;
        drv(0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0);
        push_g(0, K_CG, b, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 3'b100);
        step(1);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2);

        // Back-to-back DBG loads: grant N, rvalid N+1, next grant N+2.
        b = cyc;
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 2'b10, 1'b0);
        push_g(0, K_DG, b,     32'h0000_0200, 32'h0, 1'b0, 3'b100);
        push_r(0, K_DR, b + 1, 32'hA5A5_0200);
        push_g(0, K_DG, b + 2, 32'h0000_0204, 32'h0, 1'b0, 3'b100);
        push_r(0, K_DR, b + 3, 32'hA5A5_0204);
        step(1);
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 2'b10, 1'b0);
        step(2);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2);

        // Both writing every cycle: four CPU grants then one DBG grant, repeating.
        b = cyc;
        drv(0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h1111_1111, 2'b10, 1'b0);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h2222_2222, 2'b01, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_g(0, K_DG, b + i, 32'h0000_0400, 32'h2222_2222, 1'b1, 3'b011);
            else            push_g(0, K_CG, b + i, 32'h0000_0300, 32'h1111_1111, 1'b1, 3'b100);
        end
        step(10);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2);

        // dbg_halt: only DBG is ever granted.
        b = cyc;
        dbg_halt[0] = 1'b1;
        drv(0, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h3333_3333, 2'b10, 1'b0);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'h4444_4444, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) push_g(0, K_DG, b + i, 32'h0000_0600, 32'h4444_4444, 1'b1, 3'b100);
        step(6);
        dbg_halt[0] = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2);

        // Halt rising during a CPU read does not abort it.
        b = cyc;
        drv(0, 1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 2'b10, 1'b1);
        push_g(0, K_CG, b, 32'h0000_0700, 32'h0, 1'b0, 3'b101);
        push_r(0, K_CR, b + 1, 32'hA5A5_0700);
        step(1);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        dbg_halt[0] = 1'b1;
        step(1);
        dbg_halt[0] = 1'b0;
        step(2);

        // Asynchronous reset in the middle of a read.
        b = cyc;
        drv(0, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 2'b00, 1'b0);
        push_g(0, K_CG, b, 32'h0000_0800, 32'h0, 1'b0, 3'b000);
        step(1);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        #1;
        RST_N = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_cpu[d] = 32'h0;
            last_dbg[d] = 32'h0;
        end
        #1;
        chk("rstmid_cpu_rvalid", {31'h0, cpu_rvalid[0]}, 32'h0);
        chk("rstmid_cpu_rdata",  cpu_rdata[0],           32'h0);
        chk("rstmid_dbg_rdata",  dbg_rdata[0],           32'h0);
        step(1);
        RST_N = 1'b1;
        b = cyc;
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0000_0900, 32'h5555_5555, 2'b10, 1'b0);
        push_g(0, K_DG, b, 32'h0000_0900, 32'h5555_5555, 1'b1, 3'b100);
        step(1);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(3);

        // RD_LAT=3: DBG waits until the cycle after cpu_rvalid.
        b = cyc;
        drv(1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 2'b10, 1'b0);
        drv(1, 1'b1, 1'b1, 1'b1, 32'h0000_0A00, 32'h6666_6666, 2'b10, 1'b0);
        push_g(1, K_CG, b, 32'h0000_0600, 32'h0, 1'b0, 3'b100);
        push_r(1, K_CR, b + 3, 32'hA5A5_0600);
        push_g(1, K_DG, b + 4, 32'h0000_0A00, 32'h6666_6666, 1'b1, 3'b100);
        step(1);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(4);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(4);

        while (sb0.size() > 0) begin
            checks++; errors++;
            $display("FAIL leftover dut0: got nothing, expected kind %0d at cyc %0d", sb0[0].kind, sb0[0].cyc);
            void'(sb0.pop_front());
        end
        while (sb1.size() > 0) begin
            checks++; errors++;
            $display("FAIL leftover dut1: got nothing, expected kind %0d at cyc %0d", sb1[0].kind, sb1[0].cyc);
            void'(sb1.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
